// File: rtl/game_pkg.sv
// game_pkg
//   Shared constants for the on-screen object table: coordinate width,
//   object count and slot indices (balls first, then paddles), screen size
//   and the default clamp window used when position clamping is built in.
//   No ports; imported with "import game_pkg::*;".
package game_pkg;

    // Signed coordinate width and number of table entries
    localparam int POS_W     = 11;
    localparam int NUM_OBJ   = 9;
    localparam int OBJ_IDX_W = 4;

    // Object slots: balls occupy 0-4, paddles 5-8
    localparam int BALL0 = 0;
    localparam int BALL1 = 1;
    localparam int BALL2 = 2;
    localparam int BALL3 = 3;
    localparam int BALL4 = 4;
    localparam int PAD10 = 5;
    localparam int PAD11 = 6;
    localparam int PAD20 = 7;
    localparam int PAD21 = 8;

    // Visible screen size
    localparam int WIDTH  = 640;
    localparam int HEIGHT = 480;

    // Default clamp window lets objects sit 16 pixels past every edge
    localparam int X_MIN_DEF = -16;
    localparam int X_MAX_DEF = WIDTH + 15;
    localparam int Y_MIN_DEF = -16;
    localparam int Y_MAX_DEF = HEIGHT + 15;

endpackage

// File: rtl/frame_commit_arbiter_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin picker. Searches the request vector
//   starting at position ptr and wrapping, and returns the first hit.
//   Ports:
//     req    in  NUM_REQ  candidate requests (already masked by the caller)
//     ptr    in  PTR_W    search start position, must be < NUM_REQ
//     grant  out NUM_REQ  one-hot grant, all zero when nothing requests
//     valid  out 1        a grant was found
module rr_arbiter
    import game_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    // Walk NUM_REQ positions from ptr; the first requester found wins.
    always_comb begin
        int j;
        grant = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!valid && req[j]) begin
                grant[j] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_commit_arbiter.sv
// frame_commit_arbiter
//   Collects object position updates from several writers into a back
//   table through a round-robin req/ack arbiter and, on every frame_end
//   pulse, commits the changed entries atomically to the front table that
//   drives the renderer, so a frame never shows a half-applied update.
//   Build option: define POS_CLAMP_EN to saturate x/y writes into
//   [X_MIN, X_MAX] / [Y_MIN, Y_MAX]; without it values are stored raw.
//   Ports:
//     clk            in  1              pixel clock
//     rst_n          in  1              async reset, active high
//     req            in  NUM_REQ        write request per writer, held until ack
//     req_obj        in  NUM_REQ*4      object index per writer
//     req_x, req_y   in  NUM_REQ*POS_W  signed position per writer
//     ack            out NUM_REQ        registered one-cycle acknowledge
//     frame_end      in  1              pulse at first blanking line
//     obj_x, obj_y   out NUM_OBJ*POS_W  front table, entry 0 in the LSBs
//     frame_updated  out 1              pulse after a commit that changed the front
//     frame_cnt      out 16             accepted frame_end count, wraps
//     idx_err        out 1              sticky: a write used an index >= NUM_OBJ
module frame_commit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NUM_OBJ = game_pkg::NUM_OBJ,
    parameter int POS_W   = game_pkg::POS_W,
    parameter int X_MIN   = game_pkg::X_MIN_DEF,
    parameter int X_MAX   = game_pkg::X_MAX_DEF,
    parameter int Y_MIN   = game_pkg::Y_MIN_DEF,
    parameter int Y_MAX   = game_pkg::Y_MAX_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*4-1:0]     req_obj,
    input  logic [NUM_REQ*POS_W-1:0] req_x,
    input  logic [NUM_REQ*POS_W-1:0] req_y,
    output logic [NUM_REQ-1:0]       ack,
    input  logic                     frame_end,
    output logic [NUM_OBJ*POS_W-1:0] obj_x,
    output logic [NUM_OBJ*POS_W-1:0] obj_y,
    output logic                     frame_updated,
    output logic [15:0]              frame_cnt,
    output logic                     idx_err
);

    import game_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    logic [0:0]              state;
    logic [PTR_W-1:0]        rr_ptr;
    logic [NUM_OBJ-1:0]      dirty;
    logic signed [POS_W-1:0] front_x [NUM_OBJ];
    logic signed [POS_W-1:0] front_y [NUM_OBJ];
    logic signed [POS_W-1:0] back_x  [NUM_OBJ];
    logic signed [POS_W-1:0] back_y  [NUM_OBJ];

    logic [NUM_REQ-1:0]      req_live;
    logic [NUM_REQ-1:0]      grant;
    logic                    grant_valid;
    logic                    do_grant;
    logic [PTR_W-1:0]        gnt_idx;
    logic [PTR_W-1:0]        next_ptr;
    logic [OBJ_IDX_W-1:0]    sel_obj;
    logic signed [POS_W-1:0] sel_x;
    logic signed [POS_W-1:0] sel_y;
    logic signed [POS_W-1:0] wr_x;
    logic signed [POS_W-1:0] wr_y;
    logic                    obj_ok;

    // Saturate a coordinate into [lo, hi] with a sign-extended compare.
    function automatic logic signed [POS_W-1:0] clamp_pos(
        input logic signed [POS_W-1:0] v,
        input int                      lo,
        input int                      hi
    );
        if (int'(v) < lo) begin
            return POS_W'(lo);
        end else if (int'(v) > hi) begin
            return POS_W'(hi);
        end else begin
            return v;
        end
    endfunction

    // A writer whose ack is currently high is dropping req; masking it
    // keeps the same request from being granted a second time.
    assign req_live = req & ~ack;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req   (req_live),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (grant_valid)
    );

    assign do_grant = grant_valid && (state == ST_RUN);

    // Route the granted writer's payload and work out the next rr pointer.
    always_comb begin
        gnt_idx = '0;
        sel_obj = '0;
        sel_x   = '0;
        sel_y   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx = PTR_W'(i);
                sel_obj = req_obj[i*4 +: 4];
                sel_x   = req_x[i*POS_W +: POS_W];
                sel_y   = req_y[i*POS_W +: POS_W];
            end
        end
        obj_ok   = int'(sel_obj) < NUM_OBJ;
        next_ptr = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef POS_CLAMP_EN
        wr_x = clamp_pos(sel_x, X_MIN, X_MAX);
        wr_y = clamp_pos(sel_y, Y_MIN, Y_MAX);
`else
        wr_x = sel_x;
        wr_y = sel_y;
`endif
    end

    // RUN accepts one write per cycle into the back table; frame_end moves
    // to a single COMMIT cycle that copies only dirty entries to the front.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state         <= ST_RUN;
            rr_ptr        <= '0;
            dirty         <= '0;
            ack           <= '0;
            frame_updated <= 1'b0;
            frame_cnt     <= '0;
            idx_err       <= 1'b0;
            for (int k = 0; k < NUM_OBJ; k++) begin
                front_x[k] <= '0;
                front_y[k] <= '0;
                back_x[k]  <= '0;
                back_y[k]  <= '0;
            end
        end else begin
            ack           <= '0;
            frame_updated <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (do_grant) begin
                        ack    <= grant;
                        rr_ptr <= next_ptr;
                        if (obj_ok) begin
                            for (int k = 0; k < NUM_OBJ; k++) begin
                                if (sel_obj == OBJ_IDX_W'(k)) begin
                                    back_x[k] <= wr_x;
                                    back_y[k] <= wr_y;
                                    dirty[k]  <= 1'b1;
                                end
                            end
                        end else begin
                            idx_err <= 1'b1;
                        end
                    end
                    if (frame_end) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    for (int k = 0; k < NUM_OBJ; k++) begin
                        if (dirty[k]) begin
                            front_x[k] <= back_x[k];
                            front_y[k] <= back_y[k];
                        end
                    end
                    dirty         <= '0;
                    frame_updated <= |dirty;
                    state         <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Renderer sees the front table registers directly.
    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_front_out
        assign obj_x[g*POS_W +: POS_W] = front_x[g];
        assign obj_y[g*POS_W +: POS_W] = front_y[g];
    end

endmodule

// File: tb/tb_frame_commit_arbiter.sv
// tb_frame_commit_arbiter
//   Directed bench for frame_commit_arbiter with hand-computed expectations.
//   Inputs change 1 time unit after each rising edge and outputs are read
//   in the same slot, well clear of the next edge.
module tb_frame_commit_arbiter;

    localparam int NUM_REQ = 4;
    localparam int NUM_OBJ = 9;
    localparam int POS_W   = 11;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*4-1:0]     req_obj;
    logic [NUM_REQ*POS_W-1:0] req_x;
    logic [NUM_REQ*POS_W-1:0] req_y;
    logic [NUM_REQ-1:0]       ack;
    logic                     frame_end;
    logic [NUM_OBJ*POS_W-1:0] obj_x;
    logic [NUM_OBJ*POS_W-1:0] obj_y;
    logic                     frame_updated;
    logic [15:0]              frame_cnt;
    logic                     idx_err;

    int checks;
    int errors;

    frame_commit_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_OBJ (NUM_OBJ),
        .POS_W   (POS_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_obj       (req_obj),
        .req_x         (req_x),
        .req_y         (req_y),
        .ack           (ack),
        .frame_end     (frame_end),
        .obj_x         (obj_x),
        .obj_y         (obj_y),
        .frame_updated (frame_updated),
        .frame_cnt     (frame_cnt),
        .idx_err       (idx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Raise one writer's request with its object index and position.
    task automatic applyStimulus(input int r, input int obj, input int x, input int y);
        req[r]                  = 1'b1;
        req_obj[r*4 +: 4]       = obj[3:0];
        req_x[r*POS_W +: POS_W] = x[POS_W-1:0];
        req_y[r*POS_W +: POS_W] = y[POS_W-1:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // frame_end pulse, then the COMMIT cycle
    task automatic doFrame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] getX(input int k);
        logic [POS_W-1:0] t;
        t = obj_x[k*POS_W +: POS_W];
        return 32'(t);
    endfunction

    function automatic logic [31:0] getY(input int k);
        logic [POS_W-1:0] t;
        t = obj_y[k*POS_W +: POS_W];
        return 32'(t);
    endfunction

    // Expected coordinate truncated to the stored width
    function automatic logic [31:0] pos(input int v);
        logic [POS_W-1:0] t;
        t = v[POS_W-1:0];
        return 32'(t);
    endfunction

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        req       = '0;
        req_obj   = '0;
        req_x     = '0;
        req_y     = '0;
        frame_end = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_ack", 32'(ack), 32'h0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        checkOutput("rst_updated", 32'(frame_updated), 32'h0);
        checkOutput("rst_idx_err", 32'(idx_err), 32'h0);
        checkOutput("rst_obj_x_zero", 32'(obj_x != '0), 32'h0);
        checkOutput("rst_obj_y_zero", 32'(obj_y != '0), 32'h0);

        $display("[TB] empty frame");
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        checkOutput("empty_frame_cnt", 32'(frame_cnt), 32'd1);
        tick();
        checkOutput("empty_updated", 32'(frame_updated), 32'h0);
        checkOutput("empty_obj_x", 32'(obj_x != '0), 32'h0);

        $display("[TB] single write to paddle slot 5");
        applyStimulus(0, 5, 20, 240);
        tick();
        checkOutput("w5_ack", 32'(ack), 32'h1);
        req[0] = 1'b0;
        tick();
        checkOutput("w5_ack_drop", 32'(ack), 32'h0);
        checkOutput("w5_not_yet", getX(5), 32'h0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        checkOutput("w5_cnt", 32'(frame_cnt), 32'd2);
        checkOutput("w5_before_commit", getX(5), 32'h0);
        tick();
        checkOutput("w5_x", getX(5), pos(20));
        checkOutput("w5_y", getY(5), pos(240));
        checkOutput("w5_updated", 32'(frame_updated), 32'h1);
        tick();
        checkOutput("w5_updated_pulse", 32'(frame_updated), 32'h0);

        // Pointer sits at 1 after the grant to writer 0, so the order is 1,2,3,0
        $display("[TB] four writers at once");
        for (int i = 0; i < 4; i++) applyStimulus(i, i, 10 + i, 100 + i);
        tick();
        checkOutput("rr_ack1", 32'(ack), 32'b0010);
        req = req & ~ack;
        tick();
        checkOutput("rr_ack2", 32'(ack), 32'b0100);
        req = req & ~ack;
        tick();
        checkOutput("rr_ack3", 32'(ack), 32'b1000);
        req = req & ~ack;
        tick();
        checkOutput("rr_ack4", 32'(ack), 32'b0001);
        req = req & ~ack;
        tick();
        checkOutput("rr_idle", 32'(ack), 32'h0);
        doFrame();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rr_x%0d", i), getX(i), pos(10 + i));
            checkOutput($sformatf("rr_y%0d", i), getY(i), pos(100 + i));
        end
        checkOutput("rr_updated", 32'(frame_updated), 32'h1);

        $display("[TB] grant coinciding with frame_end");
        applyStimulus(2, 0, 100, 50);
        frame_end = 1'b1;
        tick();
        checkOutput("fe_ack", 32'(ack), 32'b0100);
        checkOutput("fe_cnt", 32'(frame_cnt), 32'd4);
        req[2] = 1'b0;
        applyStimulus(3, 1, 77, 88);
        tick();
        frame_end = 1'b0;
        checkOutput("commit_cnt_ignored", 32'(frame_cnt), 32'd4);
        checkOutput("commit_no_ack", 32'(ack), 32'h0);
        checkOutput("fe_x0", getX(0), pos(100));
        checkOutput("fe_y0", getY(0), pos(50));
        checkOutput("fe_updated", 32'(frame_updated), 32'h1);
        checkOutput("late_x1_old", getX(1), pos(11));
        tick();
        checkOutput("late_ack", 32'(ack), 32'b1000);
        req[3] = 1'b0;
        checkOutput("late_x1_held", getX(1), pos(11));
        doFrame();
        checkOutput("late_cnt", 32'(frame_cnt), 32'd5);
        checkOutput("late_x1", getX(1), pos(77));
        checkOutput("late_y1", getY(1), pos(88));

        $display("[TB] invalid object index");
        applyStimulus(1, 12, 5, 5);
        tick();
        checkOutput("bad_ack", 32'(ack), 32'b0010);
        checkOutput("bad_idx_err", 32'(idx_err), 32'h1);
        req[1] = 1'b0;
        doFrame();
        checkOutput("bad_no_update", 32'(frame_updated), 32'h0);
        checkOutput("bad_x0_kept", getX(0), pos(100));
        doFrame();
        checkOutput("bad_idx_sticky", 32'(idx_err), 32'h1);

        $display("[TB] out-of-window position");
        applyStimulus(0, 4, -300, 700);
        tick();
        checkOutput("clamp_ack", 32'(ack), 32'b0001);
        req[0] = 1'b0;
        doFrame();
`ifdef POS_CLAMP_EN
        checkOutput("clamp_x", getX(4), pos(-16));
        checkOutput("clamp_y", getY(4), pos(495));
`else
        checkOutput("raw_x", getX(4), pos(-300));
        checkOutput("raw_y", getY(4), pos(700));
`endif

        $display("[TB] reset during pending ack");
        applyStimulus(1, 6, 33, 44);
        tick();
        checkOutput("mid_ack", 32'(ack), 32'b0010);
        req[1] = 1'b0;
        rst_n  = 1'b1;
        #1;
        checkOutput("mid_rst_ack", 32'(ack), 32'h0);
        checkOutput("mid_rst_cnt", 32'(frame_cnt), 32'h0);
        checkOutput("mid_rst_idx_err", 32'(idx_err), 32'h0);
        checkOutput("mid_rst_x0", getX(0), 32'h0);
        rst_n = 1'b0;
        tick();
        doFrame();
        checkOutput("mid_discard_x6", getX(6), 32'h0);
        checkOutput("mid_discard_upd", 32'(frame_updated), 32'h0);
        checkOutput("mid_cnt", 32'(frame_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
